fft_stage_sequencer: RTL and testbench
======================================

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter FFT_N, default 10, meaning log2 of transform length; stages = FFT_N, butterflies per stage = 2^(FFT_N-1).
REQ-002 Parameter FFT_MAX_BIT_WIDTH, default 5, meaning width of the block-floating-point exponent fields.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to run one full transform.
REQ-006 hold  input  1  stalls butterfly issue while high; state and counters frozen in ISSUE.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse after the last stage drains.
REQ-009 bf_iact  output  1  butterfly issue strobe to the core.
REQ-010 bf_ictrl  output  2  bit0 = read bank (stage parity), bit1 = last-stage flag.
REQ-011 bf_addr  output  FFT_N-1  butterfly index j presented with bf_iact.
REQ-012 tw_addr  output  FFT_N-1  twiddle ROM index for j in current stage.
REQ-013 bf_oact  input  1  core result strobe, one per issued butterfly.
REQ-014 bf_max_bw  input  FFT_MAX_BIT_WIDTH  core max-bit-width report, valid with bf_oact.
REQ-015 clr_bfp  output  1  one-cycle pulse at first issue of every stage.
REQ-016 ibfp  output  FFT_MAX_BIT_WIDTH  exponent applied by the core during the current stage.
REQ-017 stage  output  log2(FFT_N)+1  current stage index, 0..FFT_N-1.

Function
REQ-018 FSM states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE: start=1 -> ISSUE with stage=0, j=0, ibfp=0, max register=0; start ignored in all other states.
REQ-020 ISSUE, hold=0: bf_iact=1, bf_addr=j, j increments each cycle; after j=2^(FFT_N-1)-1 issue -> DRAIN.
REQ-021 ISSUE, hold=1: bf_iact=0, j unchanged, no state change.
REQ-022 tw_addr = j with its low (FFT_N-1-stage) bits forced to 0 (stage 0 -> 0, last stage -> j), registered alongside bf_addr.
REQ-023 bf_addr, tw_addr, bf_ictrl, bf_iact change on the same edge; zero latency between them.
REQ-024 Outstanding counter (FFT_N bits): +1 on issue, -1 on bf_oact, unchanged when both occur in one cycle.
REQ-025 DRAIN exits when outstanding=0 and no bf_oact that cycle; to ISSUE with stage+1, j=0 if stage<FFT_N-1, else to DONE.
REQ-026 Running max: on bf_oact, max register <= max(max register, bf_max_bw); cleared on clr_bfp cycle (a simultaneous bf_oact value is still captured).
REQ-027 On DRAIN->ISSUE transition ibfp <= final max register; ibfp held constant throughout a stage.
REQ-028 DONE: done=1 one cycle, busy=0 next cycle, -> IDLE; start in DONE ignored.
REQ-029 bf_oact with outstanding=0 is a protocol error: counter saturates at 0, no state change.
REQ-030 Sequencer makes no assumption on core latency; correctness relies only on oact counting.

Reset
REQ-031 Asserting reset at any time forces IDLE within the same cycle; in-flight butterflies discarded.
REQ-032 Reset values: busy=0, done=0, bf_iact=0, bf_ictrl=0, bf_addr=0, tw_addr=0, clr_bfp=0, ibfp=0, stage=0, outstanding=0.

Structure
REQ-033 FSM state enum and bf_ictrl bit positions live in the shared FFT package.
REQ-034 Twiddle-address mask generation is one sub-module, fft_twiddle_addr_gen (combinational, parameter FFT_N).

Verification
REQ-035 FFT_N=4, core model latency 3, start -> 4 stages x 8 issues, bf_ictrl bit0 = 0,1,0,1, bit1 only in stage 3, done exactly once, busy low after.
REQ-036 Stage 2 issues j=0..7 -> tw_addr = 0,0,2,2,4,4,6,6; stage 3 -> tw_addr = j.
REQ-037 Stage 0 bf_max_bw sequence {1,3,2,...} max 3 -> ibfp=3 throughout stage 1; clr_bfp pulses 4 times.
REQ-038 hold high 5 cycles mid-ISSUE at j=4 -> no bf_iact, j resumes at 4, total issues still 32.
REQ-039 Core latency 20 (> stage length) -> next stage does not start until 8th oact of prior stage; simultaneous issue/oact keeps counter exact.
REQ-040 reset asserted in DRAIN of stage 1 -> IDLE immediately, all outputs at reset values; new start runs a full clean transform.

Source files
------------

// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types for the FFT stage sequencer.
// FSM states, control-bit positions and width helpers.
package fft_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    localparam int CTRL_W    = 2;
    localparam int CTRL_BANK = 0;
    localparam int CTRL_LAST = 1;

    function automatic int stage_width(input int fft_n);
        return $clog2(fft_n) + 1;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Sequencer <-> controller/core signal bundle.
// master = sequencer side, slave = environment side.
interface fft_stage_sequencer_if
    import fft_stage_sequencer_pkg::*;
#(
    parameter int FFT_N             = 10,
    parameter int FFT_MAX_BIT_WIDTH = 5
) ();

    localparam int AW = FFT_N - 1;
    localparam int SW = stage_width(FFT_N);

    logic                         start;
    logic                         hold;
    logic                         busy;
    logic                         done;
    logic                         bf_iact;
    logic [CTRL_W-1:0]            bf_ictrl;
    logic [AW-1:0]                bf_addr;
    logic [AW-1:0]                tw_addr;
    logic                         bf_oact;
    logic [FFT_MAX_BIT_WIDTH-1:0] bf_max_bw;
    logic                         clr_bfp;
    logic [FFT_MAX_BIT_WIDTH-1:0] ibfp;
    logic [SW-1:0]                stage;

    modport master (
        input  start, hold, bf_oact, bf_max_bw,
        output busy, done, bf_iact, bf_ictrl,
        output bf_addr, tw_addr, clr_bfp, ibfp, stage
    );

    modport slave (
        output start, hold, bf_oact, bf_max_bw,
        input  busy, done, bf_iact, bf_ictrl,
        input  bf_addr, tw_addr, clr_bfp, ibfp, stage
    );

endinterface

// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle ROM index for butterfly j in a given stage.
// Low (FFT_N-1-stage) bits of j are forced to zero.
module fft_twiddle_addr_gen
    import fft_stage_sequencer_pkg::*;
#(
    parameter int FFT_N = 10
) (
    input  logic [stage_width(FFT_N)-1:0] stage,
    input  logic [FFT_N-2:0]              j,
    output logic [FFT_N-2:0]              tw_addr
);

    localparam int AW = FFT_N - 1;
    localparam int SW = stage_width(FFT_N);

    logic [SW-1:0] shift;
    logic [AW-1:0] mask;

    // keep only the top `stage` bits of j
    always_comb begin
        shift   = SW'(AW) - stage;
        mask    = {AW{1'b1}} << shift;
        tw_addr = j & mask;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for an in-place radix-2 FFT core.
// Issues butterflies per stage, drains, tracks block exponent.
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int FFT_N             = 10,
    parameter int FFT_MAX_BIT_WIDTH = 5
) (
    input logic                   clk,
    input logic                   reset,
    fft_stage_sequencer_if.master bus
);

    localparam int AW = FFT_N - 1;
    localparam int SW = stage_width(FFT_N);
    localparam logic [AW-1:0] J_LAST     = '1;
    localparam logic [SW-1:0] STAGE_LAST = SW'(FFT_N - 1);

    seq_state_e                   state;
    logic [AW-1:0]                j;
    logic [FFT_N-1:0]             outstanding;
    logic [FFT_MAX_BIT_WIDTH-1:0] max_bw;
    logic [AW-1:0]                tw_next;
    logic [CTRL_W-1:0]            ctrl_next;
    logic                         issue;
    logic                         drained;

    assign issue   = (state == ST_ISSUE) && !bus.hold;
    assign drained = (outstanding == '0) && !bus.bf_oact;

    fft_twiddle_addr_gen #(
        .FFT_N (FFT_N)
    ) u_tw (
        .stage   (bus.stage),
        .j       (j),
        .tw_addr (tw_next)
    );

    // control bits that travel with each issued butterfly
    always_comb begin
        ctrl_next            = '0;
        ctrl_next[CTRL_BANK] = bus.stage[0];
        ctrl_next[CTRL_LAST] = (bus.stage == STAGE_LAST);
    end

    // butterflies issued but not yet returned; never wraps below zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else if (issue && !bus.bf_oact) begin
            outstanding <= outstanding + FFT_N'(1);
        end else if (!issue && bus.bf_oact && outstanding != '0) begin
            outstanding <= outstanding - FFT_N'(1);
        end
    end

    // running max of core bit-width reports within the stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_bw <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            max_bw <= '0;
        end else if (bus.clr_bfp) begin
            max_bw <= bus.bf_oact ? bus.bf_max_bw : '0;
        end else if (bus.bf_oact && bus.bf_max_bw > max_bw) begin
            max_bw <= bus.bf_max_bw;
        end
    end

    // main sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            j            <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.bf_iact  <= 1'b0;
            bus.bf_ictrl <= '0;
            bus.bf_addr  <= '0;
            bus.tw_addr  <= '0;
            bus.clr_bfp  <= 1'b0;
            bus.ibfp     <= '0;
            bus.stage    <= '0;
        end else begin
            bus.done    <= 1'b0;
            bus.bf_iact <= 1'b0;
            bus.clr_bfp <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_ISSUE;
                        bus.busy  <= 1'b1;
                        bus.stage <= '0;
                        bus.ibfp  <= '0;
                        j         <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.hold) begin
                        bus.bf_iact  <= 1'b1;
                        bus.bf_addr  <= j;
                        bus.tw_addr  <= tw_next;
                        bus.bf_ictrl <= ctrl_next;
                        bus.clr_bfp  <= (j == '0);
                        j            <= j + AW'(1);
                        if (j == J_LAST) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        if (bus.stage == STAGE_LAST) begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            bus.stage <= bus.stage + SW'(1);
                            bus.ibfp  <= max_bw;
                            j         <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized bench for fft_stage_sequencer at FFT_N=4.
// Core model returns each butterfly after a fixed latency.
module tb_fft_stage_sequencer;
    import fft_stage_sequencer_pkg::*;

    localparam int N   = 4;
    localparam int MBW = 5;
    localparam int NB  = 8;
    localparam int NS  = 4;

    typedef struct {
        int cyc;
        int stage;
        int addr;
        int tw;
        int ictrl;
        int clr;
        int ibfp;
    } iss_t;

    typedef struct {
        int due;
        int val;
        int stg;
    } pend_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fft_stage_sequencer_if #(
        .FFT_N             (N),
        .FFT_MAX_BIT_WIDTH (MBW)
    ) bus ();

    fft_stage_sequencer #(
        .FFT_N             (N),
        .FFT_MAX_BIT_WIDTH (MBW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    checks;
    int    errors;
    int    cyc;
    int    lat;
    int    bw_tab [NS][NB];
    iss_t  iss_q [$];
    pend_t pend_q [$];
    int    oact_cyc [$];
    int    oact_stg [$];
    int    done_cnt;
    int    clr_cnt;
    int    busy_gap;
    int    hold_cyc;
    int    hold_left;
    bit    in_run;
    bit    rst_hit;
    bit    timed_out;
    logic  busy_after;

    function automatic iss_t exp_issue(input int s, input int j);
        iss_t e;
        int   m;
        e.cyc   = 0;
        e.stage = s;
        e.addr  = j;
        e.tw    = (j >> (NS - 1 - s)) << (NS - 1 - s);
        e.ictrl = ((s == NS - 1) ? 2 : 0) + (s % 2);
        e.clr   = (j == 0) ? 1 : 0;
        m = 0;
        if (s > 0) begin
            for (int k = 0; k < NB; k++) begin
                if (bw_tab[s-1][k] > m) m = bw_tab[s-1][k];
            end
        end
        e.ibfp = m;
        return e;
    endfunction

    task automatic fill_tab(input bit pin);
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < NB; k++) begin
                bw_tab[s][k] = int'($urandom_range(0, 31));
            end
        end
        if (pin) begin
            for (int k = 0; k < NB; k++) bw_tab[0][k] = int'($urandom_range(0, 3));
            bw_tab[0][0] = 1;
            bw_tab[0][1] = 3;
            bw_tab[0][2] = 2;
        end
    endtask

    task automatic tick();
        iss_t  r;
        pend_t p;
        int    s;
        @(posedge clk);
        #1;
        cyc++;
        s = int'(bus.stage);
        if (in_run && !bus.busy) busy_gap++;
        if (bus.clr_bfp) clr_cnt++;
        if (bus.bf_iact) begin
            r.cyc   = cyc;
            r.stage = s;
            r.addr  = int'(bus.bf_addr);
            r.tw    = int'(bus.tw_addr);
            r.ictrl = int'(bus.bf_ictrl);
            r.clr   = int'(bus.clr_bfp);
            r.ibfp  = int'(bus.ibfp);
            iss_q.push_back(r);
            p.due = cyc + lat;
            p.stg = s;
            p.val = (s < NS) ? bw_tab[s][r.addr] : 0;
            pend_q.push_back(p);
        end
        if (bus.done) begin
            done_cnt++;
            in_run = 1'b0;
        end
        bus.bf_oact   = 1'b0;
        bus.bf_max_bw = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            bus.bf_oact   = 1'b1;
            bus.bf_max_bw = MBW'(p.val);
            oact_cyc.push_back(cyc);
            oact_stg.push_back(p.stg);
        end
    endtask

    task automatic run_transform(input int l, input int hstage,
                                 input int rstage, input bit restart);
        int n;
        iss_q.delete();
        pend_q.delete();
        oact_cyc.delete();
        oact_stg.delete();
        done_cnt  = 0;
        clr_cnt   = 0;
        busy_gap  = 0;
        lat       = l;
        hold_cyc  = -1;
        hold_left = 0;
        rst_hit   = 1'b0;
        timed_out = 1'b0;
        n = 0;
        bus.start = 1'b1;
        in_run = 1'b1;
        tick();
        bus.start = 1'b0;
        while (done_cnt == 0 && n < 3000) begin
            bus.start = restart && (n == 10);
            tick();
            n++;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) bus.hold = 1'b0;
            end else if (hold_cyc < 0 && hstage >= 0 && bus.bf_iact &&
                         int'(bus.stage) == hstage && bus.bf_addr == 3'd3) begin
                bus.hold  = 1'b1;
                hold_left = 5;
                hold_cyc  = cyc;
            end
            if (rstage >= 0 && bus.bf_iact && int'(bus.stage) == rstage &&
                bus.bf_addr == 3'd7) begin
                reset   = 1'b1;
                rst_hit = 1'b1;
                in_run  = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        if (rst_hit) return;
        timed_out = (done_cnt == 0);
        in_run = 1'b0;
        if (restart) bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.bf_iact !== 1'b0) begin errors++; $display("FAIL reset_iact: got %b want 0", bus.bf_iact); end
        checks++; if (bus.bf_ictrl !== 2'd0) begin errors++; $display("FAIL reset_ictrl: got %0d want 0", bus.bf_ictrl); end
        checks++; if (bus.bf_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.bf_addr); end
        checks++; if (bus.tw_addr !== 3'd0) begin errors++; $display("FAIL reset_tw: got %0d want 0", bus.tw_addr); end
        checks++; if (bus.clr_bfp !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b want 0", bus.clr_bfp); end
        checks++; if (bus.ibfp !== 5'd0) begin errors++; $display("FAIL reset_ibfp: got %0d want 0", bus.ibfp); end
        checks++; if (bus.stage !== 3'd0) begin errors++; $display("FAIL reset_stage: got %0d want 0", bus.stage); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        iss_t e;
        int   tw2 [NB];
        tw2 = '{0, 0, 2, 2, 4, 4, 6, 6};
        fill_tab(1'b1);
        run_transform(3, -1, -1, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout: no done within bound"); end
        checks++; if (iss_q.size() != 32) begin errors++; $display("FAIL basic_count: got %0d want 32", iss_q.size()); end
        for (int k = 0; k < iss_q.size() && k < 32; k++) begin
            e = exp_issue(k / NB, k % NB);
            checks++;
            if (iss_q[k].stage != e.stage || iss_q[k].addr != e.addr ||
                iss_q[k].tw != e.tw || iss_q[k].ictrl != e.ictrl ||
                iss_q[k].clr != e.clr || iss_q[k].ibfp != e.ibfp) begin
                errors++;
                $display("FAIL basic_issue[%0d]: got s%0d j%0d tw%0d c%0d clr%0d e%0d want s%0d j%0d tw%0d c%0d clr%0d e%0d",
                         k, iss_q[k].stage, iss_q[k].addr, iss_q[k].tw, iss_q[k].ictrl,
                         iss_q[k].clr, iss_q[k].ibfp, e.stage, e.addr, e.tw, e.ictrl, e.clr, e.ibfp);
            end
        end
        if (iss_q.size() >= 32) begin
            for (int k = 0; k < NB; k++) begin
                checks++;
                if (iss_q[16+k].tw != tw2[k]) begin
                    errors++;
                    $display("FAIL stage2_tw[%0d]: got %0d want %0d", k, iss_q[16+k].tw, tw2[k]);
                end
            end
            checks++;
            if (iss_q[8].ibfp != 3) begin errors++; $display("FAIL stage1_ibfp: got %0d want 3", iss_q[8].ibfp); end
        end
        checks++; if (clr_cnt != 4) begin errors++; $display("FAIL clr_count: got %0d want 4", clr_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
        checks++; if (busy_gap != 0) begin errors++; $display("FAIL basic_busy_gap: got %0d want 0", busy_gap); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_hold();
        int bad;
        int i3;
        iss_t e;
        fill_tab(1'b0);
        run_transform(int'($urandom_range(1, 4)), 1, -1, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL hold_timeout: no done within bound"); end
        checks++; if (iss_q.size() != 32) begin errors++; $display("FAIL hold_count: got %0d want 32", iss_q.size()); end
        checks++; if (hold_cyc < 0) begin errors++; $display("FAIL hold_trigger: got none want stage1 j3"); end
        i3 = -1;
        bad = 0;
        for (int k = 0; k < iss_q.size() && k < 32; k++) begin
            e = exp_issue(k / NB, k % NB);
            if (iss_q[k].stage == 1 && iss_q[k].addr == 3) i3 = k;
            if (iss_q[k].addr != e.addr || iss_q[k].tw != e.tw ||
                iss_q[k].stage != e.stage || iss_q[k].ibfp != e.ibfp) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_sequence: got %0d bad issues want 0", bad); end
        if (i3 >= 0 && i3 + 1 < iss_q.size()) begin
            checks++;
            if (iss_q[i3+1].addr != 4 || iss_q[i3+1].cyc != hold_cyc + 6) begin
                errors++;
                $display("FAIL hold_resume: got j%0d at +%0d want j4 at +6",
                         iss_q[i3+1].addr, iss_q[i3+1].cyc - hold_cyc);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL hold_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_long_latency();
        int   lats [2];
        int   first_cyc;
        int   n_before;
        iss_t e;
        lats = '{20, 2};
        for (int t = 0; t < 2; t++) begin
            fill_tab(1'b0);
            run_transform(lats[t], -1, -1, 1'b0);
            checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL lat%0d_timeout: no done within bound", lats[t]); end
            checks++; if (iss_q.size() != 32) begin errors++; $display("FAIL lat%0d_count: got %0d want 32", lats[t], iss_q.size()); end
            checks++; if (oact_cyc.size() != 32) begin errors++; $display("FAIL lat%0d_oacts: got %0d want 32", lats[t], oact_cyc.size()); end
            if (iss_q.size() == 32) begin
                for (int s = 0; s < NS - 1; s++) begin
                    first_cyc = iss_q[NB*(s+1)].cyc;
                    n_before = 0;
                    for (int k = 0; k < oact_cyc.size(); k++) begin
                        if (oact_stg[k] == s && oact_cyc[k] < first_cyc) n_before++;
                    end
                    checks++;
                    if (n_before != NB) begin
                        errors++;
                        $display("FAIL lat%0d_drain_s%0d: got %0d returns before next stage want %0d",
                                 lats[t], s, n_before, NB);
                    end
                    e = exp_issue(s + 1, 0);
                    checks++;
                    if (iss_q[NB*(s+1)].ibfp != e.ibfp) begin
                        errors++;
                        $display("FAIL lat%0d_ibfp_s%0d: got %0d want %0d",
                                 lats[t], s + 1, iss_q[NB*(s+1)].ibfp, e.ibfp);
                    end
                end
            end
        end
    endtask

    task automatic test_protocol_error();
        int bad;
        iss_t e;
        for (int k = 0; k < 3; k++) begin
            bus.bf_oact   = 1'b1;
            bus.bf_max_bw = MBW'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL proto_busy[%0d]: got %b want 0", k, bus.busy); end
        end
        bus.bf_oact = 1'b0;
        bus.bf_max_bw = '0;
        fill_tab(1'b0);
        run_transform(int'($urandom_range(1, 6)), -1, -1, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL proto_timeout: no done within bound"); end
        checks++; if (iss_q.size() != 32) begin errors++; $display("FAIL proto_count: got %0d want 32", iss_q.size()); end
        bad = 0;
        for (int k = 0; k < iss_q.size() && k < 32; k++) begin
            e = exp_issue(k / NB, k % NB);
            if (iss_q[k].ibfp != e.ibfp || iss_q[k].addr != e.addr) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL proto_sequence: got %0d bad issues want 0", bad); end
    endtask

    task automatic test_back_to_back();
        fill_tab(1'b0);
        run_transform(3, -1, -1, 1'b1);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL b2b_timeout: no done within bound"); end
        checks++; if (iss_q.size() != 32) begin errors++; $display("FAIL b2b_count: got %0d want 32", iss_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", done_cnt); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b want 0", busy_after); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.bf_iact !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle[%0d]: got busy %b iact %b want 0 0", k, bus.busy, bus.bf_iact);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        iss_t e;
        fill_tab(1'b0);
        run_transform(3, -1, 1, 1'b0);
        checks++; if (rst_hit !== 1'b1) begin errors++; $display("FAIL rmid_trigger: got none want stage1 drain"); end
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.bf_iact, bus.bf_ictrl, bus.bf_addr,
             bus.tw_addr, bus.clr_bfp, bus.ibfp, bus.stage} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: got busy%b done%b iact%b ctrl%0d addr%0d tw%0d clr%b ibfp%0d stage%0d want all 0",
                     bus.busy, bus.done, bus.bf_iact, bus.bf_ictrl, bus.bf_addr,
                     bus.tw_addr, bus.clr_bfp, bus.ibfp, bus.stage);
        end
        pend_q.delete();
        bus.bf_oact = 1'b0;
        bus.bf_max_bw = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        fill_tab(1'b0);
        run_transform(3, -1, -1, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rmid_timeout: no done within bound"); end
        checks++; if (iss_q.size() != 32) begin errors++; $display("FAIL rmid_count: got %0d want 32", iss_q.size()); end
        bad = 0;
        for (int k = 0; k < iss_q.size() && k < 32; k++) begin
            e = exp_issue(k / NB, k % NB);
            if (iss_q[k].stage != e.stage || iss_q[k].addr != e.addr ||
                iss_q[k].tw != e.tw || iss_q[k].ictrl != e.ictrl ||
                iss_q[k].ibfp != e.ibfp) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_sequence: got %0d bad issues want 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rmid_done: got %0d want 1", done_cnt); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL rmid_busy_after: got %b want 0", busy_after); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        lat           = 1;
        in_run        = 1'b0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.hold      = 1'b0;
        bus.bf_oact   = 1'b0;
        bus.bf_max_bw = '0;
        fill_tab(1'b0);
        test_reset();
        test_basic();
        test_hold();
        test_long_latency();
        test_protocol_error();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
